kyo_lose_sprite_fetch: RTL and testbench

Pixel-fetch stage directly upstream of the lose-pose palette lookup. For each VGA pixel it decides whether the pixel falls inside the Kyo "lose" sprite box. It computes the sprite ROM address for the current animation frame, honouring horizontal flip, and returns the 4-bit palette index the palette stage turns into RGB. It also owns the lose-animation sequencer, which plays the frames once on a trigger and then holds the final pose.

---
 rtl/kof_sprite_pkg.sv | 25 ++
 rtl/kof_anim_seq.sv | 74 +++++++
 rtl/kyo_lose_sprite_fetch.sv | 105 ++++++++++
 tb/tb_kyo_lose_sprite_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/kof_sprite_pkg.sv
// Shared sprite-fetch constants, animation state type and width helper.
// Combinational declarations only; no latency or flow control.
package kof_sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam logic [3:0] TRANSPARENT_IDX = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } anim_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/kof_anim_seq.sv
// One-shot animation sequencer: plays frames on start, then holds the last pose.
// The frame register updates one cycle after start/frame_tick; there is no backpressure.
module kof_anim_seq
    import kof_sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int HOLD_TICKS = 8,
    localparam int FRAME_W = clog2w(NUM_FRAMES),
    localparam int CNT_W   = clog2w(HOLD_TICKS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               frame_tick_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic               anim_done_o
);

    anim_state_t        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            frame_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        // start pre-empts any tick arriving in the same cycle
        if (start_i) begin
            state_d = PLAY;
            frame_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (frame_tick_i) begin
                        if (NUM_FRAMES <= 1) begin
                            state_d = HOLD;
                        end else if (cnt_q == CNT_W'(HOLD_TICKS - 1)) begin
                            cnt_d   = '0;
                            frame_d = frame_q + FRAME_W'(1);
                            if (frame_q == FRAME_W'(NUM_FRAMES - 2)) begin
                                state_d = HOLD;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    frame_d = FRAME_W'(NUM_FRAMES - 1);
                end
                default: begin
                    frame_d = '0;
                end
            endcase
        end
    end

    assign frame_o     = frame_q;
    assign anim_done_o = (state_q == HOLD);

endmodule

// File: rtl/kyo_lose_sprite_fetch.sv
// Kyo lose-pose pixel fetch: in-box test, flipped ROM addressing, palette index out.
// Two-cycle latency from DrawX/DrawY to index; one pixel per cycle, no backpressure.
module kyo_lose_sprite_fetch
    import kof_sprite_pkg::clog2w;
#(
    parameter int         SPRITE_W        = 64,
    parameter int         SPRITE_H        = 96,
    parameter int         NUM_FRAMES      = 4,
    parameter int         HOLD_TICKS      = 8,
    parameter logic [3:0] TRANSPARENT_IDX = kof_sprite_pkg::TRANSPARENT_IDX,
    localparam int        ADDR_W          = clog2w(SPRITE_W * SPRITE_H * NUM_FRAMES),
    localparam int        FRAME_W         = clog2w(NUM_FRAMES)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              facing_left,
    input  logic              start,
    input  logic              frame_tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              index_valid,
    output logic              opaque,
    output logic              anim_done
);

    logic [FRAME_W-1:0] frame;

    kof_anim_seq #(
        .NUM_FRAMES (NUM_FRAMES),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_seq (
        .clk_i        (Clk),
        .rst_ni       (Reset_n),
        .start_i      (start),
        .frame_tick_i (frame_tick),
        .frame_o      (frame),
        .anim_done_o  (anim_done)
    );

    logic [10:0]       x_end, y_end;
    logic [9:0]        dx, dy, col;
    logic              in_box;
    logic [ADDR_W-1:0] addr_d;

    // 11-bit box ends so a sprite near the right/bottom edge cannot wrap
    always_comb begin
        x_end  = {1'b0, sprite_x} + 11'(SPRITE_W);
        y_end  = {1'b0, sprite_y} + 11'(SPRITE_H);
        in_box = (DrawX >= sprite_x) && ({1'b0, DrawX} < x_end) &&
                 (DrawY >= sprite_y) && ({1'b0, DrawY} < y_end);
        dx     = DrawX - sprite_x;
        dy     = DrawY - sprite_y;
        col    = facing_left ? (10'(SPRITE_W - 1) - dx) : dx;
        addr_d = ADDR_W'(frame) * ADDR_W'(SPRITE_W * SPRITE_H)
               + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
               + ADDR_W'(col);
    end

    logic              in_box_q;
    logic              vld1_q;
    logic [ADDR_W-1:0] rom_addr_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            in_box_q   <= 1'b0;
            vld1_q     <= 1'b0;
        end else begin
            if (pix_en && in_box) begin
                rom_addr_q <= addr_d;
            end
            in_box_q <= pix_en && in_box;
            vld1_q   <= pix_en;
        end
    end

    assign rom_addr = rom_addr_q;

    logic [3:0] index_q;
    logic       opaque_q;
    logic       vld2_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            index_q  <= TRANSPARENT_IDX;
            opaque_q <= 1'b0;
            vld2_q   <= 1'b0;
        end else begin
            index_q  <= in_box_q ? rom_data : TRANSPARENT_IDX;
            opaque_q <= in_box_q && (rom_data != TRANSPARENT_IDX);
            vld2_q   <= vld1_q;
        end
    end

    assign index       = index_q;
    assign opaque      = opaque_q;
    assign index_valid = vld2_q;

endmodule

// File: tb/tb_kyo_lose_sprite_fetch.sv
// Randomized scoreboard bench for the Kyo lose-pose sprite fetch stage.
module tb_kyo_lose_sprite_fetch;
    import kof_sprite_pkg::*;

    localparam int SW = 64;
    localparam int SH = 96;
    localparam int NF = 4;
    localparam int HT = 8;
    localparam int AW = 15;

    logic          Clk, Reset_n, pix_en, facing_left, start, frame_tick;
    logic [9:0]    DrawX, DrawY, sprite_x, sprite_y;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_data, index;
    logic          index_valid, opaque, anim_done;

    kyo_lose_sprite_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_en      (pix_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .facing_left (facing_left),
        .start       (start),
        .frame_tick  (frame_tick),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .index       (index),
        .index_valid (index_valid),
        .opaque      (opaque),
        .anim_done   (anim_done)
    );

    // Sprite ROM contents: a fixed scramble of the address, hitting 4'hF regularly.
    function automatic logic [3:0] rom_fn(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a ^ (a >> 4) ^ (a >> 9);
        return t[3:0];
    endfunction

    assign rom_data = rom_fn(rom_addr);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int edge_cnt = 0;
    always @(posedge Clk) edge_cnt = edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Animation model: ticks counted since the last start.
    bit m_play;
    int m_ticks;

    function automatic int m_frame();
        int f;
        if (!m_play) return 0;
        f = m_ticks / HT;
        return (f > NF - 1) ? NF - 1 : f;
    endfunction

    function automatic bit m_done();
        return m_play && (m_ticks / HT >= NF - 1);
    endfunction

    typedef struct {
        logic [3:0] idx;
        logic       opq;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    task automatic cyc(input bit pe, input int x, input int y, input int sx, input int sy,
                       input bit fl, input bit st, input bit tk);
        exp_t e;
        int   dx, dy, col, addr;
        pix_en      = pe;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        sprite_x    = 10'(sx);
        sprite_y    = 10'(sy);
        facing_left = fl;
        start       = st;
        frame_tick  = tk;
        if (pe) begin
            e.cyc = edge_cnt + 2;
            if (x >= sx && x < sx + SW && y >= sy && y < sy + SH) begin
                dx    = x - sx;
                dy    = y - sy;
                col   = fl ? (SW - 1 - dx) : dx;
                addr  = m_frame() * SW * SH + dy * SW + col;
                e.idx = rom_fn(AW'(addr));
                e.opq = (e.idx != 4'hF);
            end else begin
                e.idx = 4'hF;
                e.opq = 1'b0;
            end
            sb.push_back(e);
        end
        if (st) begin
            m_play  = 1'b1;
            m_ticks = 0;
        end else if (tk && m_play) begin
            m_ticks = m_ticks + 1;
        end
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n) begin
            if (index_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("valid_cycle", edge_cnt, e.cyc);
                    chk("index", 32'(index), 32'(e.idx));
                    chk("opaque", 32'(opaque), 32'(e.opq));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                chk("missing_valid", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int x, y, sx, sy;
        Reset_n = 1'b0;
        pix_en = 1'b0; DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0;
        facing_left = 1'b0; start = 1'b0; frame_tick = 1'b0;
        m_play = 1'b0; m_ticks = 0;

        #12;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_index", 32'(index), 32'hF);
        chk("rst_valid", 32'(index_valid), 32'd0);
        chk("rst_opaque", 32'(opaque), 32'd0);
        chk("rst_anim_done", 32'(anim_done), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        cyc(1, 103, 52, 100, 50, 0, 0, 0);
        chk("addr_hit", 32'(rom_addr), 32'd131);
        cyc(1, 103, 52, 100, 50, 1, 0, 0);
        chk("addr_flip", 32'(rom_addr), 32'd188);
        cyc(1, 164, 52, 100, 50, 0, 0, 0);
        chk("addr_hold_outside", 32'(rom_addr), 32'd188);
        cyc(1, 5, 52, 600, 50, 0, 0, 0);
        chk("addr_hold_nowrap", 32'(rom_addr), 32'd188);
        cyc(1, 639, 52, 600, 50, 0, 0, 0);
        chk("addr_right_edge", 32'(rom_addr), 32'd167);

        cyc(0, 0, 0, 100, 50, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 100 + i, 50 + i, 100, 50, i[0], 0, 1);
        cyc(1, 100, 50, 100, 50, 0, 0, 0);
        chk("addr_frame1", 32'(rom_addr), 32'd6144);
        chk("done_frame1", 32'(anim_done), 32'(m_done()));
        for (int i = 0; i < 16; i++) cyc(1, 120, 60, 100, 50, 0, 0, 1);
        cyc(1, 100, 50, 100, 50, 0, 0, 0);
        chk("addr_frame3", 32'(rom_addr), 32'd18432);
        chk("done_frame3", 32'(anim_done), 32'd1);
        for (int i = 0; i < 100; i++) cyc(i % 3 == 0, 110, 55, 100, 50, 0, 0, 1);
        cyc(1, 100, 50, 100, 50, 0, 0, 0);
        chk("addr_held", 32'(rom_addr), 32'd18432);
        chk("done_held", 32'(anim_done), 32'd1);

        cyc(0, 0, 0, 100, 50, 0, 1, 1);
        chk("coll_state", 32'(dut.u_seq.state_q), 32'(PLAY));
        chk("coll_frame", 32'(dut.u_seq.frame_q), 32'd0);
        chk("coll_ticks", 32'(dut.u_seq.cnt_q), 32'd0);
        chk("coll_done", 32'(anim_done), 32'd0);

        for (int i = 0; i < 17; i++) cyc(1, 100 + i, 50 + 2 * i, 100, 50, 1, 0, 1);
        chk("play_frame2", 32'(dut.u_seq.frame_q), 32'(m_frame()));
        cyc(1, 130, 70, 100, 50, 0, 0, 0);
        cyc(0, 0, 0, 100, 50, 0, 0, 0);
        cyc(0, 0, 0, 100, 50, 0, 0, 0);
        cyc(0, 0, 0, 100, 50, 0, 0, 0);

        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst_index", 32'(index), 32'hF);
        chk("mid_rst_valid", 32'(index_valid), 32'd0);
        chk("mid_rst_opaque", 32'(opaque), 32'd0);
        chk("mid_rst_state", 32'(dut.u_seq.state_q), 32'(IDLE));
        chk("mid_rst_frame", 32'(dut.u_seq.frame_q), 32'd0);
        sb.delete();
        m_play = 1'b0;
        m_ticks = 0;
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            sx = int'($urandom_range(0, 639));
            sy = int'($urandom_range(0, 479));
            x  = sx + int'($urandom_range(0, 79)) - 8;
            y  = sy + int'($urandom_range(0, 111)) - 8;
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            cyc(($urandom % 4) != 0, x, y, sx, sy, $urandom % 2 == 1,
                ($urandom % 200) == 0, ($urandom % 6) == 0);
            if (i % 50 == 0) chk("rand_anim_done", 32'(anim_done), 32'(m_done()));
        end

        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
